// File: rtl/mem_stage_access.sv
// MIPS memory stage: turns EX/MEM load/store controls into a req/ready memory
// transaction, stalls upstream while busy, and loads the MEM/WB fields.
// Optional alignment check enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_access #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        StallM,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        BusErrW,
  output logic        AlignErrW
);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] waitCnt;
  logic       access;
  logic       misaligned;

  assign access = MemtoRegM | MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |ALUOutM[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // The ready cycle and the timeout cycle both release the stall so the
  // instruction leaves M on the same edge the access finishes.
  always_comb begin
    StallM = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: StallM = access & ~misaligned;
        BUSY: StallM = ~mem_ready & (waitCnt != TIMEOUT_LAST);
        default: StallM = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      BusErrW   <= 1'b0;
      AlignErrW <= 1'b0;
    end else begin
      BusErrW   <= 1'b0;
      AlignErrW <= 1'b0;
      case (state)
        IDLE: begin
          if (access && misaligned) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            AlignErrW <= 1'b1;
          end else if (access) begin
            mem_addr  <= ALUOutM;
            mem_wdata <= WriteDataM;
            mem_we    <= MemWriteM;
            mem_req   <= 1'b1;
            waitCnt   <= '0;
            state     <= BUSY;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
          end else begin
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!mem_we) ReadDataW <= mem_rdata;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            mem_req   <= 1'b0;
            state     <= IDLE;
          end else if (waitCnt == TIMEOUT_LAST) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            BusErrW   <= 1'b1;
            mem_req   <= 1'b0;
            state     <= IDLE;
          end else begin
            waitCnt   <= waitCnt + 8'd1;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: scoreboarded W-stage results,
// bus handshake, stall counts, timeout, reset and alignment behaviour.
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUOutM, WriteDataM, mem_rdata;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, MemtoRegM, MemWriteM, mem_ready;
  logic        mem_req, mem_we, StallM;
  logic [31:0] mem_addr, mem_wdata, ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW, MemtoRegW, BusErrW, AlignErrW;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
  } wexp_t;

  wexp_t       sbq[$];
  logic [31:0] expRd, expAlu;
  logic [4:0]  expWr;

  mem_stage_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .StallM(StallM),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .BusErrW(BusErrW), .AlignErrW(AlignErrW)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic pop_compare(input string name);
    wexp_t e, got;
    got = '{ReadDataW, ALUOutW, WriteRegW, RegWriteW, MemtoRegW};
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      e = sbq.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: W got rd=%h alu=%h wr=%0d rw=%b m2r=%b, required rd=%h alu=%h wr=%0d rw=%b m2r=%b",
                 name, got.rd, got.alu, got.wr, got.rw, got.m2r, e.rd, e.alu, e.wr, e.rw, e.m2r);
      end
    end
  endtask

  // Non-memory instruction: one edge, no stall, W loads from M.
  task automatic test_rtype(input string name, input logic [31:0] alu, input logic [4:0] wr, input logic rw);
    ALUOutM = alu; WriteDataM = 32'h0; WriteRegM = wr;
    RegWriteM = rw; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    expAlu = alu; expWr = wr;
    sbq.push_back('{expRd, alu, wr, rw, 1'b0});
    #1;
    checks++;
    if (StallM !== 1'b0) begin
      errors++; $display("FAIL %s stall: got %b required 0", name, StallM);
    end
    @(negedge clk);
    pop_compare(name);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL %s req: got %b required 0", name, mem_req);
    end
  endtask

  task automatic do_access(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic isStore, input int waits, input logic [31:0] rdata,
                           input logic [4:0] wreg, input logic rw);
    int stallCnt = 0;
    int reqCnt = 0;
    ALUOutM = addr; WriteDataM = wdata; WriteRegM = wreg;
    RegWriteM = rw; MemtoRegM = ~isStore; MemWriteM = isStore; mem_ready = 1'b0;
    if (!isStore) expRd = rdata;
    expAlu = addr; expWr = wreg;
    sbq.push_back('{expRd, addr, wreg, rw, ~isStore});
    #1;
    if (StallM === 1'b1) stallCnt++;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== addr || mem_we !== isStore || mem_wdata !== wdata) begin
        errors++;
        $display("FAIL %s bus%0d: got req=%b addr=%h we=%b wdata=%h required req=1 addr=%h we=%b wdata=%h",
                 name, k, mem_req, mem_addr, mem_we, mem_wdata, addr, isStore, wdata);
      end
      checks++;
      if (RegWriteW !== 1'b0 || MemtoRegW !== 1'b0) begin
        errors++;
        $display("FAIL %s bubble%0d: got rw=%b m2r=%b required 0 0", name, k, RegWriteW, MemtoRegW);
      end
      if (mem_req === 1'b1) reqCnt++;
      mem_ready = (k == waits);
      mem_rdata = rdata;
      #1;
      if (StallM === 1'b1) stallCnt++;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    pop_compare(name);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL %s idle_req: got %b required 0", name, mem_req);
    end
    checks++;
    if (stallCnt != waits + 1 || reqCnt != waits + 1) begin
      errors++;
      $display("FAIL %s counts: got stall=%0d req=%0d required %0d %0d", name, stallCnt, reqCnt, waits + 1, waits + 1);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, StallM, ReadDataW, ALUOutW, WriteRegW,
         RegWriteW, MemtoRegW, BusErrW, AlignErrW} !== '0) begin
      errors++;
      $display("FAIL reset: got req=%b we=%b addr=%h wdata=%h stall=%b rd=%h alu=%h wr=%0d rw=%b m2r=%b be=%b ae=%b required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, StallM, ReadDataW, ALUOutW, WriteRegW,
               RegWriteW, MemtoRegW, BusErrW, AlignErrW);
    end
  endtask

  task automatic test_timeout;
    int reqCnt = 0;
    ALUOutM = 32'h300; WriteDataM = 32'h0; WriteRegM = 5'd9;
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0; mem_ready = 1'b0;
    sbq.push_back('{expRd, expAlu, expWr, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_req === 1'b1) reqCnt++;
      #1;
      checks++;
      if (StallM !== (k < 3)) begin
        errors++; $display("FAIL timeout stall%0d: got %b required %b", k, StallM, (k < 3));
      end
    end
    @(negedge clk);
    checks++;
    if (BusErrW !== 1'b1 || mem_req !== 1'b0 || reqCnt != 4) begin
      errors++;
      $display("FAIL timeout: got buserr=%b req=%b reqcycles=%0d required 1 0 4", BusErrW, mem_req, reqCnt);
    end
    pop_compare("timeout_w");
    test_rtype("after_timeout", 32'h55, 5'd3, 1'b1);
    checks++;
    if (BusErrW !== 1'b0) begin
      errors++; $display("FAIL buserr_pulse: got %b required 0", BusErrW);
    end
  endtask

  task automatic test_reset_mid;
    ALUOutM = 32'h400; WriteDataM = 32'h0; WriteRegM = 5'd4;
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: got req=%b required 1", mem_req);
    end
    #1 rst = 1'b1;
    #1;
    test_reset();
    ALUOutM = 32'h0; WriteRegM = 5'd0; RegWriteM = 1'b0; MemtoRegM = 1'b0;
    expRd = '0; expAlu = '0; expWr = '0;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    test_rtype("late_ready", 32'h0, 5'd0, 1'b0);
    mem_ready = 1'b0;
  endtask

  task automatic test_misalign;
`ifdef MEM_ALIGN_CHECK_EN
    ALUOutM = 32'h102; WriteDataM = 32'h0; WriteRegM = 5'd7;
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0; mem_ready = 1'b0;
    sbq.push_back('{expRd, expAlu, expWr, 1'b0, 1'b0});
    #1;
    checks++;
    if (StallM !== 1'b0) begin
      errors++; $display("FAIL misalign_stall: got %b required 0", StallM);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || AlignErrW !== 1'b1) begin
      errors++; $display("FAIL misalign: got req=%b alignerr=%b required 0 1", mem_req, AlignErrW);
    end
    pop_compare("misalign_w");
    test_rtype("after_misalign", 32'h0, 5'd0, 1'b0);
    checks++;
    if (AlignErrW !== 1'b0) begin
      errors++; $display("FAIL alignerr_pulse: got %b required 0", AlignErrW);
    end
`else
    do_access("unaligned_load", 32'h102, 32'h0, 1'b0, 0, 32'h0BADF00D, 5'd7, 1'b1);
    checks++;
    if (AlignErrW !== 1'b0) begin
      errors++; $display("FAIL alignerr_tied: got %b required 0", AlignErrW);
    end
    test_rtype("nop_m", 32'h0, 5'd0, 1'b0);
`endif
  endtask

  task automatic test_back_to_back;
    do_access("b2b_load1", 32'h500, 32'h0, 1'b0, 0, 32'h11112222, 5'd10, 1'b1);
    do_access("b2b_load2", 32'h504, 32'h0, 1'b0, 2, 32'h33334444, 5'd11, 1'b1);
    do_access("b2b_store", 32'h508, 32'h5A5A0000, 1'b1, 1, 32'hFFFFFFFF, 5'd0, 1'b0);
    test_rtype("nop_b2b", 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
    RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;
    expRd = '0; expAlu = '0; expWr = '0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;

    test_rtype("rtype", 32'h0000_1234, 5'd5, 1'b1);
    do_access("zero_wait_load", 32'h100, 32'h0, 1'b0, 0, 32'hDEADBEEF, 5'd8, 1'b1);
    test_rtype("nop1", 32'h0, 5'd0, 1'b0);
    do_access("store_3wait", 32'h200, 32'hA5A5A5A5, 1'b1, 3, 32'h12345678, 5'd0, 1'b0);
    test_rtype("nop2", 32'h0, 5'd0, 1'b0);
    test_timeout();
    test_back_to_back();
    test_misalign();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_access.md
# mem_stage_access

Memory-stage consumer of the EX/MEM pipeline register outputs in the MIPS pipeline. It turns load/store control bits into a request/ready transaction on the data-memory port and stalls the upstream pipeline while an access is outstanding. It also loads the MEM/WB register fields (read data, ALU result, destination register, WB controls) for the write-back stage.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64, BUSY cycles without `mem_ready` before the access is aborted; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ALUOutM  in  32  ALU result; byte address for loads and stores.
- WriteDataM  in  32  store data.
- WriteRegM  in  5  destination register.
- RegWriteM, MemtoRegM, MemWriteM  in  1 each  control bits from EX/MEM.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  32  memory address, registered.
- mem_wdata  out  32  memory write data, registered.
- mem_rdata  in  32  memory read data; valid when `mem_ready` is high.
- mem_ready  in  1  completion strobe from memory.
- StallM  out  1  combinational; hold PC, IF/ID, ID/EX and EX/MEM.
- ReadDataW  out  32  load data to WB.
- ALUOutW  out  32  ALU result to WB.
- WriteRegW  out  5  destination register to WB.
- RegWriteW, MemtoRegW  out  1 each  WB controls.
- BusErrW  out  1  one-cycle flag: access timed out.
- AlignErrW  out  1  one-cycle flag: misaligned access (macro-dependent).

## Operation
- access = MemtoRegM | MemWriteM.
- States: IDLE, BUSY.
- **IDLE, no access:**
  - W fields load from the M inputs each edge.
  - StallM = 0.
  - ReadDataW holds its value.
- **IDLE, access:**
  - StallM = 1.
  - At the edge, load mem_addr = ALUOutM, mem_wdata = WriteDataM, mem_we = MemWriteM; set mem_req = 1; clear the wait counter; go to BUSY.
  - W receives a bubble: RegWriteW = 0, MemtoRegW = 0. Other W fields hold.
- **BUSY, mem_ready = 0:**
  - StallM = 1.
  - Counter increments.
  - W receives a bubble.
- **BUSY, mem_ready = 1:**
  - StallM = 0.
  - At the edge:
    - ReadDataW = mem_rdata, but only if mem_we = 0.
    - ALUOutW, WriteRegW, RegWriteW and MemtoRegW load from the M inputs.
    - mem_req goes to 0; return to IDLE.
- **BUSY, counter = TIMEOUT_CYCLES − 1 and mem_ready = 0:**
  - StallM = 0.
  - At the edge: bubble to W, BusErrW = 1 for one cycle, mem_req goes to 0, return to IDLE.
  - The instruction retires with no register write.
- mem_ready is ignored in IDLE.
- mem_addr, mem_we and mem_wdata are stable while mem_req = 1.
- A store never updates ReadDataW; RegWriteW passes through RegWriteM unchanged.
- Counter is 8 bits and never wraps: the timeout fires first.

## Timing
- Non-memory instruction: latency 1 cycle, no stall.
- Memory access: StallM is high for the IDLE cycle plus every BUSY cycle before the ready cycle.
  - Zero-wait memory (ready in the first BUSY cycle) gives 1 stall cycle; the result appears in W 2 edges after the instruction enters M.
  - N wait cycles give N+1 stall cycles.
- Back-to-back accesses: after the ready edge, the next EX/MEM contents are seen in IDLE, so there are ≥1 idle-bus cycles between requests.
- Reset (async, any state):
  - State = IDLE, counter = 0.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - All W outputs = 0; BusErrW = 0, AlignErrW = 0.
  - StallM forced to 0 while rst = 1.
  - An in-flight access is dropped; a late mem_ready after reset is ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - In IDLE, an access with ALUOutM[1:0] ≠ 0 issues no request and raises no stall.
  - At the edge: bubble to W, AlignErrW = 1 for one cycle, state stays IDLE.
- MEM_ALIGN_CHECK_EN undefined:
  - No alignment check; full ALUOutM drives mem_addr.
  - AlignErrW is tied to 0.

## Test plan
- R-type pass-through: ALUOutM=0x0000_1234, WriteRegM=5, RegWriteM=1 → next edge ALUOutW=0x1234, WriteRegW=5, RegWriteW=1; StallM never high; mem_req=0.
- Zero-wait load: MemtoRegM=1, ALUOutM=0x100, memory ready in the first BUSY cycle with rdata=0xDEADBEEF → StallM high exactly 1 cycle; mem_req high 1 cycle with mem_addr=0x100, mem_we=0; ReadDataW=0xDEADBEEF, MemtoRegW=1 at the following edge.
- Store with 3 wait cycles: MemWriteM=1, ALUOutM=0x200, WriteDataM=0xA5A5A5A5 → mem_we=1, mem_wdata stable for 4 req cycles; StallM high 4 cycles; ReadDataW unchanged; RegWriteW=0 throughout.
- Timeout: TIMEOUT_CYCLES=4, load with mem_ready held 0 → mem_req high 4 cycles; BusErrW pulses 1 cycle; RegWriteW=0; StallM low on the 4th BUSY cycle; FSM back in IDLE.
- Reset mid-access: assert rst in the 2nd BUSY cycle → mem_req, StallM and all W outputs go to 0 immediately; mem_ready pulsed after release causes no W update.
- Misalign (with MEM_ALIGN_CHECK_EN): load at ALUOutM=0x102 → no mem_req, no stall, AlignErrW=1 for 1 cycle, RegWriteW=0. Without the macro: normal access at 0x102, AlignErrW=0.
